// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
//
// Column-scanned RGB LED matrix driver with a double-buffered framebuffer.
// The front buffer is shown one column at a time: a dark BLANK interval, then
// (2^PWM_BITS-1) PWM slots during which each row lights while its intensity
// exceeds the slot number. Pixels are written into the back buffer. A
// requested swap takes effect on the last ON clock of the final column.
//
// Optional feature: define LED_GLOBAL_BRIGHT_EN to add bright_i, a global
// intensity ceiling sampled at the start of every column.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   wr_en_i          pixel write strobe
//   wr_col_i         write column (values >= COLS are ignored)
//   wr_row_i         write row    (values >= ROWS are ignored)
//   wr_rgb_i         pixel {R, G, B}, PWM_BITS each, R in the MSBs
//   swap_req_i       request a front/back exchange at the end of the frame
//   bright_i         global brightness ceiling (LED_GLOBAL_BRIGHT_EN only)
//   swap_pend_o      a swap is waiting for the end of the frame
//   swap_ack_o       one-clock pulse on the clock the swap happens
//   led_r_o/g_o/b_o  active-high row drives
//   led_selc_o       active-low one-hot column select
//   led_rst_o        panel reset, high for RST_CYCLES clocks after reset
//   frame_start_o    one-clock pulse at the start of column 0
// -----------------------------------------------------------------------------
module led_matrix_scanner #(
   parameter int ROWS         = 8,
   parameter int COLS         = 12,
   parameter int PWM_BITS     = 4,
   parameter int SLOT_CYCLES  = 2,
   parameter int BLANK_CYCLES = 4,
   parameter int RST_CYCLES   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en_i,
   input  logic [$clog2(COLS)-1:0] wr_col_i,
   input  logic [$clog2(ROWS)-1:0] wr_row_i,
   input  logic [3*PWM_BITS-1:0]   wr_rgb_i,
   input  logic                    swap_req_i,
`ifdef LED_GLOBAL_BRIGHT_EN
   input  logic [PWM_BITS-1:0]     bright_i,
`endif
   output logic                    swap_pend_o,
   output logic                    swap_ack_o,
   output logic [ROWS-1:0]         led_r_o,
   output logic [ROWS-1:0]         led_g_o,
   output logic [ROWS-1:0]         led_b_o,
   output logic [COLS-1:0]         led_selc_o,
   output logic                    led_rst_o,
   output logic                    frame_start_o
);

   localparam int COL_W     = $clog2(COLS);
   localparam int NUM_SLOTS = (1 << PWM_BITS) - 1;
   localparam int CNT_MAX   = (RST_CYCLES > BLANK_CYCLES) ? RST_CYCLES : BLANK_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int SUB_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   localparam logic [1:0] ST_RSTP  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_ON    = 2'd2;

   // Two framebuffers; index front_q is displayed, ~front_q is written.
   logic [3*PWM_BITS-1:0] fb_q [2][COLS][ROWS];

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [PWM_BITS-1:0] slot_q, slot_d;
   logic [SUB_W-1:0]    sub_q, sub_d;
   logic                front_q;
   logic                swap_pend_q, swap_pend_d;
   logic                last_on, swap_fire;

   logic [ROWS-1:0]     led_r_q, led_g_q, led_b_q;
   logic [ROWS-1:0]     led_r_d, led_g_d, led_b_d;
   logic [COLS-1:0]     led_selc_q, led_selc_d;
   logic                led_rst_q, frame_start_q, frame_start_d;
   logic [PWM_BITS-1:0] ceiling;

   function automatic logic [PWM_BITS-1:0] sat(input logic [PWM_BITS-1:0] v,
                                              input logic [PWM_BITS-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

`ifdef LED_GLOBAL_BRIGHT_EN
   logic [PWM_BITS-1:0] bright_q;

   // Latched once per column so the ceiling never changes mid-column.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bright_q <= '0;
      else if (state_q == ST_BLANK && cnt_q == '0)
         bright_q <= bright_i;
   end

   assign ceiling = bright_q;
`else
   // An all-ones ceiling leaves every pixel value unchanged.
   assign ceiling = '1;
`endif

   // Last ON clock of the final column: the only point a swap may happen.
   assign last_on   = (state_q == ST_ON) && (col_q == COL_W'(COLS - 1)) &&
                      (slot_q == PWM_BITS'(NUM_SLOTS - 1)) &&
                      (sub_q == SUB_W'(SLOT_CYCLES - 1));
   assign swap_fire = last_on && swap_pend_q;

   // A request on the swap clock itself re-arms the flag for the next frame.
   assign swap_pend_d = swap_fire ? swap_req_i : (swap_pend_q | swap_req_i);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      slot_d  = slot_q;
      sub_d   = sub_q;
      case (state_q)
         ST_RSTP: begin
            if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               col_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_BLANK: begin
            if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
               state_d = ST_ON;
               cnt_d   = '0;
               slot_d  = '0;
               sub_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ON: begin
            if (sub_q == SUB_W'(SLOT_CYCLES - 1)) begin
               sub_d = '0;
               if (slot_q == PWM_BITS'(NUM_SLOTS - 1)) begin
                  state_d = ST_BLANK;
                  slot_d  = '0;
                  col_d   = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end else begin
               sub_d = sub_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RSTP;
            cnt_d   = '0;
         end
      endcase
   end

   // Pin values are computed from the current state and registered, so the
   // panel sees them one clock later and never glitches between columns.
   always_comb begin
      led_r_d       = '0;
      led_g_d       = '0;
      led_b_d       = '0;
      led_selc_d    = '1;
      frame_start_d = (state_q == ST_BLANK) && (col_q == '0) && (cnt_q == '0);
      if (state_q == ST_ON) begin
         led_selc_d = ~(COLS'(1) << col_q);
         for (int r = 0; r < ROWS; r++) begin
            led_r_d[r] = sat(fb_q[front_q][col_q][r][3*PWM_BITS-1 -: PWM_BITS], ceiling) > slot_q;
            led_g_d[r] = sat(fb_q[front_q][col_q][r][2*PWM_BITS-1 -: PWM_BITS], ceiling) > slot_q;
            led_b_d[r] = sat(fb_q[front_q][col_q][r][PWM_BITS-1 -: PWM_BITS], ceiling) > slot_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q       <= ST_RSTP;
         cnt_q         <= '0;
         col_q         <= '0;
         slot_q        <= '0;
         sub_q         <= '0;
         front_q       <= 1'b0;
         swap_pend_q   <= 1'b0;
         led_r_q       <= '0;
         led_g_q       <= '0;
         led_b_q       <= '0;
         led_selc_q    <= '1;
         led_rst_q     <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         col_q         <= col_d;
         slot_q        <= slot_d;
         sub_q         <= sub_d;
         front_q       <= front_q ^ swap_fire;
         swap_pend_q   <= swap_pend_d;
         led_r_q       <= led_r_d;
         led_g_q       <= led_g_d;
         led_b_q       <= led_b_d;
         led_selc_q    <= led_selc_d;
         led_rst_q     <= (state_q == ST_RSTP);
         frame_start_q <= frame_start_d;
      end
   end

   // NOTE: the framebuffers have no reset; their contents survive rst_n and
   // a reset branch would turn the storage into per-bit resettable flops.
   // Writing through the pre-edge front_q makes a write on the swap clock land
   // in the buffer that is about to become front.
   always_ff @(posedge clk) begin
      if (wr_en_i && (int'(wr_col_i) < COLS) && (int'(wr_row_i) < ROWS))
         fb_q[~front_q][wr_col_i][wr_row_i] <= wr_rgb_i;
   end

   assign swap_pend_o   = swap_pend_q;
   assign swap_ack_o    = swap_fire;
   assign led_r_o       = led_r_q;
   assign led_g_o       = led_g_q;
   assign led_b_o       = led_b_q;
   assign led_selc_o    = led_selc_q;
   assign led_rst_o     = led_rst_q;
   assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scanner
//
// Directed bench for led_matrix_scanner at default parameters (column period
// 34 clocks, frame 408 clocks). cyc counts rising edges since rst_n release;
// the state machine enters frame k, column 0, BLANK at cyc 16 + 408*k, and
// the registered pins show that state one clock later. Outputs are sampled on
// the falling edge. Define LED_GLOBAL_BRIGHT_EN to exercise bright_i as well.
// -----------------------------------------------------------------------------
module tb_led_matrix_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en;
   logic [3:0]  wr_col;
   logic [2:0]  wr_row;
   logic [11:0] wr_rgb;
   logic        swap_req;
   logic [3:0]  bright;
   logic        swap_pend, swap_ack, led_rst, frame_start;
   logic [7:0]  led_r, led_g, led_b;
   logic [11:0] led_selc;

   int cyc;
   int ack_cnt = 0;
   int n_vec   = 0;
   int n_err   = 0;

   led_matrix_scanner dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en_i       (wr_en),
      .wr_col_i      (wr_col),
      .wr_row_i      (wr_row),
      .wr_rgb_i      (wr_rgb),
      .swap_req_i    (swap_req),
`ifdef LED_GLOBAL_BRIGHT_EN
      .bright_i      (bright),
`endif
      .swap_pend_o   (swap_pend),
      .swap_ack_o    (swap_ack),
      .led_r_o       (led_r),
      .led_g_o       (led_g),
      .led_b_o       (led_b),
      .led_selc_o    (led_selc),
      .led_rst_o     (led_rst),
      .frame_start_o (frame_start)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (swap_ack) ack_cnt <= ack_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int target);
      int guard = 0;
      while (cyc < target) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            $display("FAIL wait_cyc: target %0d not reached, at %0d", target, cyc);
            $fatal(1, "bench timeout");
         end
      end
   endtask

   task automatic write_px(input int at, input logic [3:0] col, input logic [2:0] row,
                           input logic [11:0] rgb);
      wait_cyc(at);
      wr_en  = 1'b1;
      wr_col = col;
      wr_row = row;
      wr_rgb = rgb;
      wait_cyc(at + 1);
      wr_en  = 1'b0;
   endtask

   // Count clocks with row 2 lit, over n consecutive sample points.
   task automatic count_row2(input int first, input int n, output int nr, output int ng,
                             output int nb);
      nr = 0; ng = 0; nb = 0;
      for (int k = 0; k < n; k++) begin
         wait_cyc(first + k);
         nr += int'(led_r[2]);
         ng += int'(led_g[2]);
         nb += int'(led_b[2]);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_led_r"},  led_r, 32'h0);
      check({tag, "_led_g"},  led_g, 32'h0);
      check({tag, "_led_b"},  led_b, 32'h0);
      check({tag, "_selc"},   led_selc, 32'hFFF);
      check({tag, "_ledrst"}, led_rst, 32'h1);
      check({tag, "_pend"},   swap_pend, 32'h0);
      check({tag, "_ack"},    swap_ack, 32'h0);
      check({tag, "_fstart"}, frame_start, 32'h0);
   endtask

   initial begin
      int nr, ng, nb, ack_snap;
      wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_rgb = '0; swap_req = 1'b0;
      bright = 4'hF;

      // Power-up reset, checked without any clock edge.
      #2 rst_n = 1'b0;
      #1 check_reset_values("por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // LED_RST for 16 clocks, then column 0 BLANK and FRAME_START.
      wait_cyc(1);  check("ledrst_first", led_rst, 32'h1);
      wait_cyc(16); check("ledrst_last", led_rst, 32'h1);
                    check("fstart_before", frame_start, 32'h0);
      wait_cyc(17); check("ledrst_off", led_rst, 32'h0);
                    check("fstart_pulse", frame_start, 32'h1);
                    check("selc_blank0", led_selc, 32'hFFF);
      wait_cyc(18); check("fstart_end", frame_start, 32'h0);
      wait_cyc(20); check("selc_blank3", led_selc, 32'hFFF);
      wait_cyc(21); check("selc_col0", led_selc, 32'hFFE);

      // Frame 0: fill back buffer, request a swap for the frame end.
      write_px(30, 4'd0,  3'd2, 12'hF00);
      write_px(32, 4'd1,  3'd2, 12'h500);
      write_px(34, 4'd2,  3'd2, 12'h000);
      write_px(36, 4'd12, 3'd2, 12'h0FF);
      wait_cyc(60); swap_req = 1'b1;
      wait_cyc(61); swap_req = 1'b0;
                    check("f0_pend_set", swap_pend, 32'h1);
      wait_cyc(423); check("f0_ack", swap_ack, 32'h1);
                     check("f0_pend_hold", swap_pend, 32'h1);
      wait_cyc(424); check("f0_ack_end", swap_ack, 32'h0);
                     check("f0_pend_clr", swap_pend, 32'h0);
                     check("f1_fstart_pre", frame_start, 32'h0);
      wait_cyc(425); check("f1_fstart", frame_start, 32'h1);

      // Frame 1: the new front shows R15 / R5 / R0 in columns 0..2, row 2.
      count_row2(425, 34, nr, ng, nb);
      check("c0_r15_hi", nr, 32'd30);
      check("c0_g_hi", ng, 32'd0);
      check("c0_b_hi", nb, 32'd0);
      count_row2(459, 14, nr, ng, nb);
      check("c1_r5_first", nr, 32'd10);
      count_row2(473, 20, nr, ng, nb);
      check("c1_r5_rest", nr, 32'd0);
      count_row2(493, 34, nr, ng, nb);
      check("c2_r0_hi", nr, 32'd0);

      // Back buffer (index 0) gets B15 at col 5; a write on the swap clock
      // goes to the buffer that becomes front.
      write_px(540, 4'd5, 3'd2, 12'h00F);
      wait_cyc(600); swap_req = 1'b1;
      wait_cyc(601); swap_req = 1'b0;
      wait_cyc(831); check("f1_ack", swap_ack, 32'h1);
      wr_en = 1'b1; wr_col = 4'd3; wr_row = 3'd2; wr_rgb = 12'hA00;
      wait_cyc(832); wr_en = 1'b0;
                     check("f1_pend_clr", swap_pend, 32'h0);
                     check("f1_ack_end", swap_ack, 32'h0);

      // Frame 2: requests at frame clocks 100 and 200, one ack at 407.
      wait_cyc(840); ack_snap = ack_cnt;
      wait_cyc(932); check("f2_pend_idle", swap_pend, 32'h0);
      swap_req = 1'b1;
      wait_cyc(933); swap_req = 1'b0;
                     check("f2_pend_101", swap_pend, 32'h1);
      wait_cyc(938); check("c3_blank_r", led_r[2], 32'h0);
      wait_cyc(939); check("c3_swapwr_first", led_r[2], 32'h1);
      wait_cyc(958); check("c3_swapwr_last", led_r[2], 32'h1);
      wait_cyc(959); check("c3_swapwr_off", led_r[2], 32'h0);
      wait_cyc(1032); swap_req = 1'b1;
      wait_cyc(1033); swap_req = 1'b0;
                      check("f2_pend_200", swap_pend, 32'h1);
      wait_cyc(1238); check("f2_pend_406", swap_pend, 32'h1);
                      check("f2_ack_406", swap_ack, 32'h0);
      wait_cyc(1239); check("f2_ack_407", swap_ack, 32'h1);
                      check("f2_pend_407", swap_pend, 32'h1);
      swap_req = 1'b1;
      wait_cyc(1240); swap_req = 1'b0;
                      check("f2_rearm", swap_pend, 32'h1);
                      check("f2_ack_end", swap_ack, 32'h0);

      // Frame 3: buffer 1 is front again, unchanged.
      wait_cyc(1245); check("f2_ack_count", ack_cnt - ack_snap, 32'd1);
                      check("f3_c0_r_on", led_r[2], 32'h1);
      wait_cyc(1274); check("f3_c0_r_last", led_r[2], 32'h1);
      wait_cyc(1275); check("f3_c1_blank", led_r[2], 32'h0);
      wait_cyc(1647); check("f3_ack", swap_ack, 32'h1);
      wait_cyc(1648); check("f3_pend_clr", swap_pend, 32'h0);

      // Frame 4: buffer 0 returns with its contents intact.
      wait_cyc(1698); swap_req = 1'b1;
      wait_cyc(1699); swap_req = 1'b0;
                      check("f4_pend_set", swap_pend, 32'h1);
      wait_cyc(1755); check("f4_c3_first", led_r[2], 32'h1);
      wait_cyc(1774); check("f4_c3_last", led_r[2], 32'h1);
      wait_cyc(1775); check("f4_c3_off", led_r[2], 32'h0);
      wait_cyc(1828); check("f4_c5_b", led_b[2], 32'h1);
                      check("f4_c5_r", led_r[2], 32'h0);
                      check("f4_c5_selc", led_selc, 32'hFDF);

      // Reset in the middle of column 5 ON, checked with no clock edge.
      #2 rst_n = 1'b0;
      #1 check_reset_values("mid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(16);  check("rr_ledrst_on", led_rst, 32'h1);
      wait_cyc(17);  check("rr_ledrst_off", led_rst, 32'h0);
                     check("rr_pend", swap_pend, 32'h0);
      wait_cyc(190); check("rr_c5_pre", led_b[2], 32'h0);
      wait_cyc(191); check("rr_c5_first", led_b[2], 32'h1);
      wait_cyc(220); check("rr_c5_last", led_b[2], 32'h1);
      wait_cyc(221); check("rr_c5_post", led_b[2], 32'h0);

`ifdef LED_GLOBAL_BRIGHT_EN
      // Ceiling of 3 limits a B15 pixel to 3 slots = 6 clocks.
      wait_cyc(230); bright = 4'd3;
      count_row2(595, 34, nr, ng, nb);
      check("bright3_b15", nb, 32'd6);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
